// File: rtl/aes_ctr_keystream_ctrl_if.sv
// Handshake bundle between the CTR keystream controller (slave) and its host/cores (master).
interface aes_ctr_keystream_ctrl_if #(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned BLOCK_W   = 128,
    parameter int unsigned NONCE_W   = 16
);
    localparam int unsigned DATA_W = NUM_LANES * BLOCK_W;

    logic               start;
    logic               mode;
    logic [NONCE_W-1:0] nonce;
    logic               abort;
    logic               busy;
    logic               done;

    logic               iv_valid;
    logic               iv_ready;
    logic [DATA_W-1:0]  iv_data;

    logic               ks_valid;
    logic [DATA_W-1:0]  ks_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [NUM_LANES-1:0] out_lane_en;
    logic                 out_last;

    modport master (
        output start, mode, nonce, abort, iv_ready, ks_valid, ks_data, out_ready,
        input  busy, done, iv_valid, iv_data, out_valid, out_data, out_lane_en, out_last
    );

    modport slave (
        input  start, mode, nonce, abort, iv_ready, ks_valid, ks_data, out_ready,
        output busy, done, iv_valid, iv_data, out_valid, out_data, out_lane_en, out_last
    );
endinterface

// File: rtl/aes_ctr_keystream_ctrl.sv
// CTR-mode IV issuer and keystream re-pairing buffer for NUM_LANES parallel AES cores,
// with run start/done, abort with in-flight discard, and credit-based flow control.
module aes_ctr_keystream_ctrl #(
    parameter int unsigned NUM_LANES  = 3,
    parameter int unsigned BLOCK_W    = 128,
    parameter int unsigned NONCE_W    = 16,
    parameter int unsigned CTR_W      = 6,
    parameter int unsigned XOF_BLOCKS = 44,
    parameter int unsigned PRF_BLOCKS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_ctr_keystream_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = NUM_LANES * BLOCK_W;
    localparam int unsigned PAD_W  = BLOCK_W - NONCE_W - CTR_W;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W  = CTR_W + 1;

    localparam int unsigned XOF_B   = (XOF_BLOCKS + NUM_LANES - 1) / NUM_LANES;
    localparam int unsigned PRF_B   = (PRF_BLOCKS + NUM_LANES - 1) / NUM_LANES;
    localparam int unsigned XOF_REM = XOF_BLOCKS - (XOF_B - 1) * NUM_LANES;
    localparam int unsigned PRF_REM = PRF_BLOCKS - (PRF_B - 1) * NUM_LANES;

    localparam logic [NUM_LANES-1:0] ALL_LANES = '1;
    localparam logic [NUM_LANES-1:0] XOF_MASK  = NUM_LANES'((32'd1 << XOF_REM) - 32'd1);
    localparam logic [NUM_LANES-1:0] PRF_MASK  = NUM_LANES'((32'd1 << PRF_REM) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [NUM_LANES-1:0] mask;
        logic                 last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [NUM_LANES-1:0] mask;
        logic                 last;
    } res_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     batches_q;
    logic [NUM_LANES-1:0] last_mask_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     discard;
    logic                 busy_q;
    logic                 done_q;

    tag_t                 tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tag_wp;
    logic [PTR_W-1:0]     tag_rp;
    logic [CNT_W-1:0]     tag_cnt;

    res_t                 res_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     res_wp;
    logic [PTR_W-1:0]     res_rp;
    logic [CNT_W-1:0]     res_cnt;

    logic                 last_batch_c;
    logic [NUM_LANES-1:0] cur_mask_c;
    logic                 iv_valid_c;
    logic                 iv_fire;
    logic                 out_valid_c;
    logic                 out_fire;
    logic                 abort_hit;
    logic                 start_ok;
    logic                 ks_drop;
    logic                 ks_take;
    logic [CNT_W-1:0]     discard_abort;
    logic [CNT_W-1:0]     discard_dec;
    logic [DATA_W-1:0]    iv_data_c;
    tag_t                 tag_head;
    res_t                 res_head;
    res_t                 res_in;

    assign last_batch_c = (idx == batches_q - IDX_W'(1));
    assign cur_mask_c   = last_batch_c ? last_mask_q : ALL_LANES;
    assign iv_valid_c   = (state == S_ISSUE) && (outstanding < CNT_W'(FIFO_DEPTH));
    assign iv_fire      = iv_valid_c && bus.iv_ready;
    assign out_valid_c  = (res_cnt != '0);
    assign out_fire     = out_valid_c && bus.out_ready;
    assign abort_hit    = bus.abort && (state != S_IDLE);
    assign start_ok     = (state == S_IDLE) && (discard == '0) && bus.start && !bus.abort;
    assign tag_head     = tag_mem[tag_rp];
    assign res_head     = res_mem[res_rp];

    // Beats owed to an aborted run are dropped before any tag is consulted.
    assign ks_drop = bus.ks_valid && (discard != '0);
    assign ks_take = bus.ks_valid && (discard == '0) && (tag_cnt != '0);

    assign discard_dec   = discard - CNT_W'(ks_drop);
    assign discard_abort = tag_cnt + CNT_W'(iv_fire) - CNT_W'(ks_take);

    // IV batch: lane 0 in the MSBs, counter = idx*NUM_LANES + lane, disabled lanes zero.
    always_comb begin
        iv_data_c = '0;
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            if (iv_valid_c && cur_mask_c[j]) begin
                iv_data_c[(NUM_LANES-j)*BLOCK_W-1 -: BLOCK_W] =
                    {nonce_q, {PAD_W{1'b0}}, CTR_W'(idx * IDX_W'(NUM_LANES) + IDX_W'(j))};
            end
        end
    end

    // Keystream is masked with the tag of the batch it belongs to.
    always_comb begin
        res_in      = '0;
        res_in.mask = tag_head.mask;
        res_in.last = tag_head.last;
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            if (tag_head.mask[j]) begin
                res_in.data[(NUM_LANES-j)*BLOCK_W-1 -: BLOCK_W] =
                    bus.ks_data[(NUM_LANES-j)*BLOCK_W-1 -: BLOCK_W];
            end
        end
    end

    assign bus.iv_valid    = iv_valid_c;
    assign bus.iv_data     = iv_data_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_data    = out_valid_c ? res_head.data : '0;
    assign bus.out_lane_en = out_valid_c ? res_head.mask : '0;
    assign bus.out_last    = out_valid_c && res_head.last;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // Run control FSM with credit and discard accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            batches_q   <= '0;
            last_mask_q <= '0;
            nonce_q     <= '0;
            outstanding <= '0;
            discard     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_hit) begin
                state       <= S_IDLE;
                outstanding <= '0;
                discard     <= discard_abort;
                busy_q      <= (discard_abort != '0);
            end else begin
                outstanding <= outstanding + CNT_W'(iv_fire) - CNT_W'(out_fire);
                discard     <= discard_dec;
                case (state)
                    S_IDLE: begin
                        busy_q <= (discard_dec != '0);
                        if (start_ok) begin
                            state       <= S_ISSUE;
                            idx         <= '0;
                            nonce_q     <= bus.nonce;
                            batches_q   <= bus.mode ? IDX_W'(PRF_B) : IDX_W'(XOF_B);
                            last_mask_q <= bus.mode ? PRF_MASK : XOF_MASK;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (iv_fire) begin
                            idx <= idx + IDX_W'(1);
                            if (last_batch_c) state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (out_fire && res_head.last) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Tag FIFO pointers: push on issue, pop on returned keystream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else if (abort_hit) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else begin
            if (iv_fire) tag_wp <= tag_wp + PTR_W'(1);
            if (ks_take) tag_rp <= tag_rp + PTR_W'(1);
            tag_cnt <= tag_cnt + CNT_W'(iv_fire) - CNT_W'(ks_take);
        end
    end

    always_ff @(posedge clk) begin
        if (iv_fire) tag_mem[tag_wp] <= '{mask: cur_mask_c, last: last_batch_c};
    end

    // Result FIFO pointers: push on returned keystream, pop on output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else if (abort_hit) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (ks_take)  res_wp <= res_wp + PTR_W'(1);
            if (out_fire) res_rp <= res_rp + PTR_W'(1);
            res_cnt <= res_cnt + CNT_W'(ks_take) - CNT_W'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (ks_take) res_mem[res_wp] <= res_in;
    end

endmodule

// File: tb/tb_aes_ctr_keystream_ctrl.sv
// Directed bench for aes_ctr_keystream_ctrl: vector table of full runs plus hand-written
// back-pressure, restart-while-busy, abort/discard and asynchronous reset sequences.
module tb_aes_ctr_keystream_ctrl;
    localparam int unsigned NL  = 3;
    localparam int unsigned BW  = 128;
    localparam int unsigned NW  = 16;
    localparam int unsigned DW  = NL * BW;
    localparam int          LAT = 14;
    localparam logic [BW-1:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [DW-1:0] KS_PAT = {KEY, KEY ^ 128'h1, KEY ^ 128'h2};

    typedef struct {
        logic          mode;
        logic [NW-1:0] nonce;
        int            exp_b;
        logic [NL-1:0] exp_mask;
        int            exp_ctr;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } core_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [NL-1:0] mask;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_ctr_keystream_ctrl_if #(.NUM_LANES(NL), .BLOCK_W(BW), .NONCE_W(NW)) bus ();

    aes_ctr_keystream_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int iv_fires = 0, out_fires = 0, done_cnt = 0, ks_beats = 0;
    int done_ncyc = 0, last_out_ncyc = 0, last_ctr0 = 0;
    logic [NL-1:0] last_out_mask = '0;
    int base_iv = 0, base_out = 0, base_done = 0;

    bit            m_active = 1'b0;
    logic [NW-1:0] m_nonce  = '0;
    int            m_k = 0, m_b = 0;
    logic [NL-1:0] m_last_mask = '0;

    core_t core_q[$];
    exp_t  exp_q[$];
    vec_t  vecs[4];

    function automatic void check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] model_iv(logic [NW-1:0] n, int k, logic [NL-1:0] mask);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < int'(NL); j++)
            if (mask[j]) v[(int'(NL)-j)*int'(BW)-1 -: BW] = {n, 106'b0, 6'(k*int'(NL)+j)};
        return v;
    endfunction

    function automatic logic [DW-1:0] mask_lanes(logic [DW-1:0] d, logic [NL-1:0] mask);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < int'(NL); j++)
            if (mask[j]) v[(int'(NL)-j)*int'(BW)-1 -: BW] = d[(int'(NL)-j)*int'(BW)-1 -: BW];
        return v;
    endfunction

    // Observe handshakes mid-cycle, score IVs and outputs, and feed the core model.
    always @(negedge clk) begin : mon
        logic [NL-1:0] mk;
        logic [DW-1:0] ev;
        exp_t          e;
        ncyc++;
        if (!rst) begin
            if (bus.iv_valid && bus.iv_ready) begin
                iv_fires++;
                last_ctr0 = int'(bus.iv_data[2*BW +: 6]);
                if (!m_active || m_k >= m_b) begin
                    check("iv_unexpected", DW'(1), DW'(0));
                end else begin
                    mk = (m_k == m_b - 1) ? m_last_mask : '1;
                    ev = model_iv(m_nonce, m_k, mk);
                    check("iv_data", bus.iv_data, ev);
                    core_q.push_back('{due: ncyc + LAT, data: ev ^ KS_PAT});
                    exp_q.push_back('{data: mask_lanes(ev ^ KS_PAT, mk), mask: mk, last: (m_k == m_b - 1)});
                    m_k++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                out_fires++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", DW'(bus.out_valid), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_lane_en", DW'(bus.out_lane_en), DW'(e.mask));
                    check("out_last", DW'(bus.out_last), DW'(e.last));
                    if (bus.out_last) begin
                        last_out_ncyc = ncyc;
                        last_out_mask = bus.out_lane_en;
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_ncyc = ncyc;
            end
            if (bus.ks_valid) ks_beats++;
        end
    end

    // AES core model: fixed latency, returns in issue order, no backpressure.
    initial begin
        bus.ks_valid = 1'b0;
        bus.ks_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_q.size() != 0 && core_q[0].due <= ncyc) begin
                bus.ks_valid = 1'b1;
                bus.ks_data  = core_q[0].data;
                void'(core_q.pop_front());
            end else begin
                bus.ks_valid = 1'b0;
                bus.ks_data  = '0;
            end
        end
    end

    task automatic start_run(input logic m, input logic [NW-1:0] n);
        int t;
        int rem;
        t           = m ? 8 : 44;
        m_b         = (t + int'(NL) - 1) / int'(NL);
        rem         = t - (m_b - 1) * int'(NL);
        m_last_mask = NL'((1 << rem) - 1);
        m_nonce     = n;
        m_k         = 0;
        m_active    = 1'b1;
        base_iv     = iv_fires;
        base_out    = out_fires;
        base_done   = done_cnt;
        bus.mode    = m;
        bus.nonce   = n;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", DW'(bus.busy), DW'(1));
    endtask

    task automatic finish_run(input int exp_b, input logic [NL-1:0] exp_mask, input int exp_ctr);
        for (int i = 0; i < 3000 && done_cnt == base_done; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_count", DW'(done_cnt - base_done), DW'(1));
        check("iv_batches", DW'(iv_fires - base_iv), DW'(exp_b));
        check("out_batches", DW'(out_fires - base_out), DW'(exp_b));
        check("done_latency", DW'(done_ncyc - last_out_ncyc), DW'(1));
        check("last_lane_en", DW'(last_out_mask), DW'(exp_mask));
        check("last_ctr0", DW'(last_ctr0), DW'(exp_ctr));
        @(posedge clk);
        #1;
        check("done_pulse_len", DW'(bus.done), DW'(0));
        check("busy_idle", DW'(bus.busy), DW'(0));
        check("out_valid_idle", DW'(bus.out_valid), DW'(0));
        m_active = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, DW'(bus.busy), DW'(0));
        check({tag, "_done"}, DW'(bus.done), DW'(0));
        check({tag, "_iv_valid"}, DW'(bus.iv_valid), DW'(0));
        check({tag, "_iv_data"}, bus.iv_data, DW'(0));
        check({tag, "_out_valid"}, DW'(bus.out_valid), DW'(0));
        check({tag, "_out_data"}, bus.out_data, DW'(0));
        check({tag, "_out_lane_en"}, DW'(bus.out_lane_en), DW'(0));
        check({tag, "_out_last"}, DW'(bus.out_last), DW'(0));
    endtask

    initial begin : main
        int k0;
        bit out_seen;
        bit start_pulsed;
        vecs[0] = '{mode: 1'b0, nonce: 16'hA55A, exp_b: 15, exp_mask: 3'b011, exp_ctr: 42};
        vecs[1] = '{mode: 1'b1, nonce: 16'hA55A, exp_b: 3,  exp_mask: 3'b011, exp_ctr: 6};
        vecs[2] = '{mode: 1'b1, nonce: 16'h0001, exp_b: 3,  exp_mask: 3'b011, exp_ctr: 6};
        vecs[3] = '{mode: 1'b0, nonce: 16'hFFFF, exp_b: 15, exp_mask: 3'b011, exp_ctr: 42};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.nonce     = '0;
        bus.abort     = 1'b0;
        bus.iv_ready  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full runs, ready always high.
        for (int v = 0; v < 4; v++) begin
            start_run(vecs[v].mode, vecs[v].nonce);
            finish_run(vecs[v].exp_b, vecs[v].exp_mask, vecs[v].exp_ctr);
        end

        // Output backpressure: credits cap issue at FIFO_DEPTH batches.
        bus.out_ready = 1'b0;
        start_run(1'b0, 16'h3C3C);
        repeat (40) @(posedge clk);
        #1;
        check("bp_issued", DW'(iv_fires - base_iv), DW'(4));
        check("bp_iv_valid", DW'(bus.iv_valid), DW'(0));
        check("bp_out_valid", DW'(bus.out_valid), DW'(1));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_credit_return", DW'(bus.iv_valid), DW'(1));
        finish_run(15, 3'b011, 42);

        // start during ISSUE with other nonce/mode must be ignored.
        start_run(1'b0, 16'hA55A);
        repeat (5) @(posedge clk);
        #1;
        bus.nonce = 16'h1111;
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        finish_run(15, 3'b011, 42);

        // Abort with exactly two batches in flight.
        start_run(1'b0, 16'h0BAD);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (iv_fires - base_iv >= 2) break;
        end
        bus.iv_ready = 1'b0;
        check("abort_inflight", DW'(iv_fires - base_iv), DW'(2));
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.iv_ready = 1'b1;
        m_active     = 1'b0;
        exp_q.delete();
        check("abort_busy", DW'(bus.busy), DW'(1));
        check("abort_iv_valid", DW'(bus.iv_valid), DW'(0));
        check("abort_done", DW'(bus.done), DW'(0));
        k0           = ks_beats;
        out_seen     = 1'b0;
        start_pulsed = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            out_seen  = out_seen | bus.out_valid;
            if (ks_beats - k0 == 1) check("discard_busy_mid", DW'(bus.busy), DW'(1));
            if (ks_beats - k0 >= 2) break;
            if (!start_pulsed && i == 2) begin
                bus.start    = 1'b1;
                start_pulsed = 1'b1;
            end
            if (start_pulsed && i == 4) check("start_while_busy", DW'(bus.iv_valid), DW'(0));
        end
        bus.start = 1'b0;
        check("discard_beats", DW'(ks_beats - k0), DW'(2));
        check("discard_busy_low", DW'(bus.busy), DW'(0));
        check("discard_no_out", DW'(out_seen), DW'(0));
        start_run(1'b1, 16'h5EED);
        finish_run(3, 3'b011, 6);

        // Asynchronous reset mid-DRAIN, then a clean repeat of the first run.
        start_run(1'b0, 16'hA55A);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (iv_fires - base_iv >= 15) break;
        end
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_busy", DW'(bus.busy), DW'(1));
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_active = 1'b0;
        exp_q.delete();
        core_q.delete();
        repeat (2) @(posedge clk);
        #1;
        core_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_run(1'b0, 16'hA55A);
        finish_run(15, 3'b011, 42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
